// File: rtl/multi_packet_scoreboard.sv
// Multi-packet scoreboard: shadows a FIFO-ordered DUT with an exact occupancy model,
// follows up to NTRACK tagged packets to the exit, and flags data, latency and flag errors.
module multi_packet_scoreboard #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 8,
  parameter int NTRACK  = 2,
  parameter int MAX_LAT = 16,
  parameter int CNTWID  = $clog2(DEPTH) + 1,
  parameter int IDW     = (NTRACK > 1) ? $clog2(NTRACK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              start,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [WIDTH-1:0]  data_out,
  input  logic              empty_ref,
  input  logic              full_ref,
  output logic [NTRACK-1:0] trk_busy,
  output logic              check_vld,
  output logic [IDW-1:0]    check_id,
  output logic              mismatch,
  output logic              cap_drop,
  output logic              timeout,
  output logic              occ_err,
  output logic              err_sticky
);

  localparam int AGEW = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
  localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(MAX_LAT);
  localparam logic [AGEW-1:0] AGE_TRIP = (MAX_LAT > 0) ? AGEW'(MAX_LAT - 1) : '0;

  // trk_busy mirrors the per-tracker state and doubles as the FSM debug view.
  typedef enum logic {TRK_IDLE = 1'b0, TRK_TRACKING = 1'b1} trk_state_e;

  trk_state_e        state_q [NTRACK];
  trk_state_e        state_d [NTRACK];
  logic [WIDTH-1:0]  data_q  [NTRACK];
  logic [WIDTH-1:0]  data_d  [NTRACK];
  logic [CNTWID-1:0] pos_q   [NTRACK];
  logic [CNTWID-1:0] pos_d   [NTRACK];
  logic [AGEW-1:0]   age_q   [NTRACK];
  logic [AGEW-1:0]   age_d   [NTRACK];
  logic [CNTWID-1:0] occ_q, occ_d;
  logic              err_q, err_d;

  logic              empty, full, acc_push, acc_pop;
  logic              cap_any, cap_en;
  logic [IDW-1:0]    cap_idx;
  logic [NTRACK-1:0] exit_v, trip_v;
  logic [WIDTH-1:0]  exit_data;

  // Handshake: a push is accepted only when not full, a pop only when not empty;
  // both can be accepted in the same cycle.
  always_comb begin
    empty    = (occ_q == '0);
    full     = (occ_q == CNTWID'(DEPTH));
    acc_push = push & ~full;
    acc_pop  = pop & ~empty;
    occ_d    = occ_q + CNTWID'(acc_push) - CNTWID'(acc_pop);
  end

  // Lowest-index idle tracker wins the capture; the exiting tracker is still busy here.
  always_comb begin
    cap_any = 1'b0;
    cap_idx = '0;
    for (int i = NTRACK - 1; i >= 0; i--) begin
      if (state_q[i] == TRK_IDLE) begin
        cap_any = 1'b1;
        cap_idx = IDW'(i);
      end
    end
    cap_en = start & acc_push & cap_any;
  end

  always_comb begin
    for (int i = 0; i < NTRACK; i++) begin
      exit_v[i] = (state_q[i] == TRK_TRACKING) & acc_pop & (pos_q[i] == CNTWID'(1));
      trip_v[i] = (MAX_LAT != 0) & (state_q[i] == TRK_TRACKING) &
                  (age_q[i] == AGE_TRIP) & ~exit_v[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NTRACK; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      pos_d[i]   = pos_q[i];
      age_d[i]   = age_q[i];
      case (state_q[i])
        TRK_IDLE: begin
          if (cap_en && (cap_idx == IDW'(i))) begin
            state_d[i] = TRK_TRACKING;
            data_d[i]  = data_in;
            pos_d[i]   = occ_q + CNTWID'(1) - CNTWID'(acc_pop);
            age_d[i]   = '0;
          end
        end
        TRK_TRACKING: begin
          if (exit_v[i]) begin
            state_d[i] = TRK_IDLE;
            pos_d[i]   = '0;
            age_d[i]   = '0;
          end else begin
            if (acc_pop) pos_d[i] = pos_q[i] - CNTWID'(1);
            if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGEW'(1);
          end
        end
        default: state_d[i] = TRK_IDLE;
      endcase
    end
  end

  always_comb begin
    check_id  = '0;
    exit_data = '0;
    for (int i = 0; i < NTRACK; i++) begin
      trk_busy[i] = (state_q[i] == TRK_TRACKING);
      if (exit_v[i]) begin
        check_id  = IDW'(i);
        exit_data = data_q[i];
      end
    end
    check_vld  = |exit_v;
    mismatch   = check_vld & (data_out != exit_data);
    cap_drop   = start & acc_push & ~cap_any;
    timeout    = |trip_v;
    occ_err    = (empty != empty_ref) | (full != full_ref);
    err_sticky = err_q;
    err_d      = err_q | mismatch | timeout | occ_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NTRACK; i++) begin
        state_q[i] <= TRK_IDLE;
        data_q[i]  <= '0;
        pos_q[i]   <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
      for (int i = 0; i < NTRACK; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        pos_q[i]   <= pos_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_packet_scoreboard.sv
// Bench for multi_packet_scoreboard: a packet-queue reference model predicts every cycle,
// a monitor compares the DUT outputs against the queued predictions.
module tb_multi_packet_scoreboard;

  localparam int DEPTH   = 4;
  localparam int WIDTH   = 8;
  localparam int NTRACK  = 2;
  localparam int MAX_LAT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             push, pop, start;
  logic [WIDTH-1:0] data_in, data_out;
  logic             empty_ref, full_ref;
  logic [NTRACK-1:0] trk_busy;
  logic             check_vld;
  logic [0:0]       check_id;
  logic             mismatch, cap_drop, timeout, occ_err, err_sticky;

  multi_packet_scoreboard #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NTRACK(NTRACK), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .start(start),
    .data_in(data_in), .data_out(data_out), .empty_ref(empty_ref), .full_ref(full_ref),
    .trk_busy(trk_busy), .check_vld(check_vld), .check_id(check_id), .mismatch(mismatch),
    .cap_drop(cap_drop), .timeout(timeout), .occ_err(occ_err), .err_sticky(err_sticky)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_seen_chk = 0;
  int n_seen_to = 0;

  // Reference model: the DUT contents as a packet queue; tag = owning tracker or -1.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               tag;
    int               age;
  } ent_t;
  ent_t mq[$];
  bit   mbusy[NTRACK];
  bit   msticky;

  typedef struct packed {
    logic [1:0] busy;
    logic       cv;
    logic       cd;
    logic       to;
    logic       oe;
    logic       es;
  } st_t;
  typedef struct packed {
    logic [0:0] id;
    logic       mm;
  } ck_t;
  logic [$bits(st_t)-1:0] st_q[$];
  logic [$bits(ck_t)-1:0] ck_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle of stimulus plus the model's prediction for it
  task automatic step(input bit p, input bit q, input bit s,
                      input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] dout,
                      input bit bad_e = 1'b0, input bit bad_f = 1'b0);
    int  occ, cid, free;
    bit  m_full, m_empty, ap, app, cv, mm, cd, to, oe;
    st_t st;
    ck_t ck;
    @(negedge clk);
    foreach (mq[k]) if (mq[k].tag >= 0) mq[k].age = mq[k].age + 1;
    occ     = mq.size();
    m_full  = (occ == DEPTH);
    m_empty = (occ == 0);
    push = p; pop = q; start = s; data_in = din; data_out = dout;
    empty_ref = m_empty ^ bad_e;
    full_ref  = m_full ^ bad_f;
    ap  = p && !m_full;
    app = q && !m_empty;
    cv = 0; cid = 0; mm = 0;
    if (app && mq[0].tag >= 0) begin
      cv = 1; cid = mq[0].tag; mm = (dout != mq[0].data);
    end
    free = -1;
    for (int t = 0; t < NTRACK; t++) if (!mbusy[t] && free < 0) free = t;
    cd = s && ap && (free < 0);
    to = 0;
    foreach (mq[k]) if (mq[k].tag >= 0 && mq[k].age == MAX_LAT && !(app && k == 0)) to = 1;
    oe = (m_empty != empty_ref) || (m_full != full_ref);
    st = '{busy: {mbusy[1], mbusy[0]}, cv: cv, cd: cd, to: to, oe: oe, es: msticky};
    st_q.push_back(st);
    if (cv) begin
      ck = '{id: cid[0:0], mm: mm};
      ck_q.push_back(ck);
    end
    if (app) begin
      if (mq[0].tag >= 0) mbusy[mq[0].tag] = 1'b0;
      void'(mq.pop_front());
    end
    if (ap) begin
      ent_t e;
      e.data = din;
      e.tag  = (s && free >= 0) ? free : -1;
      e.age  = 0;
      if (e.tag >= 0) mbusy[e.tag] = 1'b1;
      mq.push_back(e);
    end
    msticky = msticky | mm | to | oe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(negedge clk);
    #3;
    push = 0; pop = 0; start = 0; data_in = '0; data_out = '0;
    empty_ref = 1'b1; full_ref = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_trk_busy", trk_busy, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_check_vld", check_vld, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cap_drop", cap_drop, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_occ_err", occ_err, 0);
    chk("rst_pending_checks", ck_q.size(), 0);
    mq.delete();
    ck_q.delete();
    for (int t = 0; t < NTRACK; t++) mbusy[t] = 1'b0;
    msticky = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    #2;
    if (st_q.size() > 0) begin
      st_t e;
      e = st_t'(st_q.pop_front());
      chk("trk_busy", trk_busy, e.busy);
      chk("check_vld", check_vld, e.cv);
      chk("cap_drop", cap_drop, e.cd);
      chk("timeout", timeout, e.to);
      chk("occ_err", occ_err, e.oe);
      chk("err_sticky", err_sticky, e.es);
      if (timeout) n_seen_to++;
      if (check_vld) begin
        n_seen_chk++;
        if (ck_q.size() == 0) begin
          chk("unexpected_check", 1, 0);
        end else begin
          ck_t c;
          c = ck_t'(ck_q.pop_front());
          chk("check_id", check_id, c.id);
          chk("mismatch", mismatch, c.mm);
        end
      end else begin
        chk("mismatch_idle", mismatch, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    bit p, q, s, be, bf;
    logic [WIDTH-1:0] din, dout;
    rst = 1'b0;
    push = 0; pop = 0; start = 0; data_in = '0; data_out = '0;
    empty_ref = 1'b1; full_ref = 1'b0;
    msticky = 1'b0;
    for (int t = 0; t < NTRACK; t++) mbusy[t] = 1'b0;

    // 1: tagged packet exits with matching data
    apply_reset();
    step(1, 0, 1, 8'h11, 8'h00);
    step(1, 0, 0, 8'h22, 8'h00);
    step(0, 1, 0, 8'h00, 8'h11);
    step(0, 1, 0, 8'h00, 8'h22);
    idle(2);

    // 2: corrupted exit data, sticky holds
    apply_reset();
    step(1, 0, 1, 8'h11, 8'h00);
    step(1, 0, 0, 8'h22, 8'h00);
    step(0, 1, 0, 8'h00, 8'h12);
    step(0, 1, 0, 8'h00, 8'h22);
    idle(4);

    // 3: third tagged push has no free tracker
    apply_reset();
    base = n_seen_chk;
    step(1, 0, 1, 8'h11, 8'h00);
    step(1, 0, 1, 8'h22, 8'h00);
    step(1, 0, 1, 8'h33, 8'h00);
    step(0, 1, 0, 8'h00, 8'h11);
    step(0, 1, 0, 8'h00, 8'h22);
    step(0, 1, 0, 8'h00, 8'h33);
    idle(1);
    chk("s3_check_count", n_seen_chk - base, 2);

    // 4: push dropped while full, then a lying full flag
    apply_reset();
    step(1, 0, 1, 8'h01, 8'h00);
    step(1, 0, 0, 8'h02, 8'h00);
    step(1, 0, 0, 8'h03, 8'h00);
    step(1, 0, 0, 8'h04, 8'h00);
    step(1, 1, 0, 8'h05, 8'h01);
    step(0, 0, 0, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(2);

    // 5: watchdog fires once, packet still checked later
    apply_reset();
    base = n_seen_to;
    step(1, 0, 1, 8'hAA, 8'h00);
    idle(22);
    step(0, 1, 0, 8'h00, 8'hAA);
    idle(1);
    chk("s5_timeout_count", n_seen_to - base, 1);

    // 6: reset with packets in flight
    apply_reset();
    step(1, 0, 1, 8'h11, 8'h00);
    step(1, 0, 0, 8'h22, 8'h00);
    apply_reset();
    step(0, 1, 0, 8'h00, 8'h11);
    step(1, 0, 0, 8'h44, 8'h00);
    step(0, 1, 0, 8'h00, 8'h44);
    idle(1);

    // randomized traffic with occasional corruption and flag lies
    for (int r = 0; r < 10; r++) begin
      apply_reset();
      for (int i = 0; i < 300; i++) begin
        p    = ($urandom_range(0, 99) < 55);
        q    = ($urandom_range(0, 99) < 50);
        s    = ($urandom_range(0, 99) < 40);
        din  = WIDTH'($urandom_range(0, 255));
        dout = (mq.size() > 0) ? mq[0].data : WIDTH'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) dout = dout ^ WIDTH'(1 << $urandom_range(0, 7));
        be   = ($urandom_range(0, 99) == 0);
        bf   = ($urandom_range(0, 99) == 0);
        step(p, q, s, din, dout, be, bf);
      end
    end

    @(negedge clk);
    #4;
    chk("drain_status", st_q.size(), 0);
    chk("drain_checks", ck_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_packet_scoreboard.md
Name: multi_packet_scoreboard

Overview:
- Parametrised successor to the single-magic-packet scoreboard.
- Tracks up to NTRACK tagged packets at once through a FIFO-ordered DUT and checks each packet's data when it exits.
- Keeps an exact occupancy model, so it can check the DUT's empty/full flags every cycle.
- Adds a latency watchdog and a sticky error flag; sits beside the DUT in formal and simulation harnesses.

Parameters:
- DEPTH, 8: DUT capacity in entries.
- WIDTH, 8: data width.
- NTRACK, 2: number of concurrent packet trackers (>=1).
- MAX_LAT, 16: cycles a tracked packet may stay in the DUT; 0 disables the watchdog.
- CNTWID, $clog2(DEPTH)+1: occupancy/position counter width.
- IDW, $clog2(NTRACK) (min 1): tracker index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- push  in  1  DUT enqueue request.
- pop  in  1  DUT dequeue request.
- start  in  1  tag the packet pushed this cycle.
- data_in  in  WIDTH  DUT input data.
- data_out  in  WIDTH  DUT output data, valid in a cycle with an accepted pop.
- empty_ref  in  1  DUT empty flag.
- full_ref  in  1  DUT full flag.
- trk_busy  out  NTRACK  per-tracker busy bits.
- check_vld  out  1  a tracked packet exits this cycle.
- check_id  out  IDW  index of the exiting tracker.
- mismatch  out  1  check_vld & (data_out != stored packet).
- cap_drop  out  1  start & acc_push with no free tracker.
- timeout  out  1  a tracker reached MAX_LAT this cycle.
- occ_err  out  1  (empty != empty_ref) | (full != full_ref).
- err_sticky  out  1  latched OR of mismatch, timeout and occ_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - occ=0; all trackers IDLE; stored data, positions and ages = 0; err_sticky=0.
  - Every output is 0 except occ_err, which follows empty=1/full=0 against the ref inputs.
- Occupancy model:
  - empty = (occ==0); full = (occ==DEPTH).
  - acc_push = push & ~full. A push while full is dropped, even if pop is also high.
  - acc_pop = pop & ~empty. A pop while empty is ignored, even if push is also high.
  - occ_next = occ + acc_push - acc_pop. occ never exceeds DEPTH and never goes negative.
- Tracker FSM, per tracker: IDLE -> TRACKING -> IDLE. Fields: data[WIDTH], pos[CNTWID], age.
- Capture (IDLE->TRACKING):
  - Occurs on start & acc_push, taken by the lowest-index IDLE tracker.
  - Stores data <= data_in, pos <= occ + 1 - acc_pop (1 = head of queue), age <= 0.
  - Only one capture per cycle.
  - If no tracker is IDLE: cap_drop=1 for that cycle and nothing is captured.
- TRACKING, each cycle:
  - If acc_pop and pos > 1: pos decrements.
  - If acc_pop and pos == 1: the packet exits this cycle. check_vld=1 and check_id=index, both combinational in the same cycle as the pop; the tracker returns to IDLE at the next edge.
  - At most one tracker can have pos==1, so at most one check per cycle.
  - A tracker that exits in a cycle is IDLE at the next edge, so the lowest-index free tracker may be re-captured in the following cycle.
  - A capture and another tracker's exit may occur in the same cycle.
- mismatch: combinational, same cycle as check_vld.
- Watchdog:
  - age increments every TRACKING cycle, saturating at MAX_LAT.
  - timeout=1 for exactly one cycle, when age becomes MAX_LAT and the packet does not exit that cycle.
  - The tracker keeps tracking after a timeout.
  - MAX_LAT=0: timeout is held at 0.
- occ_err: combinational, evaluated every cycle against the exact model.
- err_sticky: registered. Set at the edge after any cycle with mismatch, timeout or occ_err; cleared only by reset.
- Mid-operation reset: all tracking is abandoned immediately; no check fires for packets that were in flight.

Test Plan:
(All scenarios use DEPTH=4, WIDTH=8, NTRACK=2, MAX_LAT=16, with refs driven correctly unless stated.)
1. Push 0x11 with start, push 0x22, pop with data_out=0x11 -> check_vld=1, check_id=0, mismatch=0 on that pop; trk_busy=2'b00 next cycle.
2. Same sequence but data_out=0x12 on the exit pop -> mismatch=1 that cycle; err_sticky=1 from the next cycle until reset.
3. Three consecutive pushes with start -> trackers 0 and 1 capture, trk_busy=2'b11; third push gives cap_drop=1; after pops return 0x11, 0x22, 0x33, checks fire on the first two pops only.
4. Four pushes, then push & pop together with full_ref=1 -> push dropped, pop accepted, occ=3; then drive full_ref=1 while occ=3 -> occ_err=1.
5. Capture 0xAA, no pops -> timeout=1 for exactly one cycle, 16 cycles after capture; err_sticky=1 next cycle; a later pop with 0xAA still gives check_vld=1, mismatch=0.
6. Tracker busy with occ=2, assert rst=0 between edges -> trk_busy=0 and err_sticky=0 immediately; after release, a pop does not produce check_vld.
